proc_run_monitor: RTL and testbench
===================================

Name: proc_run_monitor

Overview:
Synthesizable run controller and monitor that wraps a multicycle RISC core (design2 and later generations) for simulation and board bring-up.
- Sequences the core's reset.
- Gates the core's execution enable.
- Counts cycles and committed instructions.
- Ends the run on halt, hang (PC self-loop) or cycle timeout, and reports sticky status.
- Replaces the fixed "run N ps then $finish" bench flow with a parametrised, restartable controller.

Parameters:
- ADDR_W, 16, width of the core PC.
- CNT_W, 32, width of the cycle and instruction counters.
- RST_CYCLES, 4, number of cycles core_rst is held after start (must be at least 1).
- MAX_CYCLES, 200, RUN-state cycle budget before timeout (must be at least 1).
- HANG_LIMIT, 3, number of consecutive commits at an identical PC that declares a hang (must be at least 2).
- TRACE_DEPTH, 8, PC trace buffer entries (power of 2; used only with RUNMON_TRACE_EN).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin or restart a run.
- halt_i  in  1  core signals a halt instruction was executed.
- commit_i  in  1  one-cycle pulse per retired instruction.
- pc_i  in  ADDR_W  PC of the instruction retiring this cycle (valid when commit_i is high).
- core_rst  out  1  reset to the core.
- core_en  out  1  execution enable to the core.
- running  out  1  high while in RUN.
- done  out  1  sticky: run ended by halt.
- timeout  out  1  sticky: cycle budget exhausted.
- hang  out  1  sticky: PC self-loop detected.
- cycle_cnt  out  CNT_W  RUN cycles elapsed.
- instr_cnt  out  CNT_W  commits observed in RUN.
- trc_idx  in  log2(TRACE_DEPTH)  trace read index; 0 is the newest entry (trace builds only).
- trc_pc  out  ADDR_W  PC read from the trace (trace builds only).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, RST_HOLD, RUN, DONE, TIMEOUT, HANG.
- Reset values: state IDLE, core_rst=1, core_en=0, running=0, done=0, timeout=0, hang=0, cycle_cnt=0, instr_cnt=0, hold counter 0, hang counter 0, trace cleared to 0.
- rst high in any state, including mid-RUN, returns to the reset values on the next edge. rst has priority over start.
- All outputs are registered. Every response appears on the edge after the triggering input.

State transitions:
- IDLE: core_rst=1, core_en=0. start moves to RST_HOLD.
- RST_HOLD: core_rst=1 for exactly RST_CYCLES cycles. On entry, clear the counters, the sticky flags and the hang tracker. Then move to RUN.
- RUN:
  - core_rst=0, core_en=1, running=1.
  - cycle_cnt increments every cycle.
  - instr_cnt increments on commit_i.
  - Both counters saturate at all-ones.
  - start is ignored.
- Terminal states (DONE, TIMEOUT, HANG):
  - core_rst=0, core_en=0, running=0.
  - Counters are frozen; the matching flag stays high.
  - start moves to RST_HOLD, which clears all flags.

RUN exit conditions, evaluated in the same cycle:
- Halt: halt_i=1 moves to DONE. A commit in the halt cycle is counted.
- Hang:
  - On each commit, if pc_i equals the last committed PC, the hang counter increments; otherwise it loads 1.
  - When the count reaches HANG_LIMIT, move to HANG.
  - Non-commit cycles leave the tracker unchanged.
- Timeout: when cycle_cnt equals MAX_CYCLES-1 in RUN, move to TIMEOUT. cycle_cnt ends at MAX_CYCLES.
- Priority on simultaneous events: halt, then hang, then timeout.

Optional Feature:
- Macro: RUNMON_TRACE_EN.
- Defined:
  - A circular buffer of TRACE_DEPTH entries holds the most recent committed PCs, written on every commit_i in RUN.
  - The write pointer wraps modulo TRACE_DEPTH.
  - trc_pc = entry trc_idx positions older than the newest. This is a combinational read of registered storage.
  - The buffer is cleared in RST_HOLD.
- Undefined: the trace ports, storage and pointer do not exist. All other behaviour is identical.

Decomposition:
- Shared package runmon_pkg holds:
  - the state enum: IDLE=0, RST_HOLD=1, RUN=2, DONE=3, TIMEOUT=4, HANG=5;
  - the status-code constants;
  - a saturating-increment function.
- One sub-module: runmon_trace_buf, the circular PC buffer. It is instantiated only under RUNMON_TRACE_EN.

Test Plan:
- Normal halt: rst, then start. Required response:
  - core_rst stays high exactly 4 cycles, then core_en rises.
  - Drive 10 commits at distinct PCs and halt_i at RUN cycle 50.
  - End state: done=1, cycle_cnt=51, instr_cnt=10, core_en=0.
- Timeout: MAX_CYCLES=200, no halt_i, distinct PCs. Required response: timeout=1 exactly 200 cycles after RUN entry; cycle_cnt=200; done=0.
- Hang: commits at PCs 0x10, 0x14, 0x14, 0x14. Required response: hang=1 on the edge after the third 0x14 commit; instr_cnt=4.
- Simultaneous events: halt_i together with the third repeated-PC commit on cycle MAX_CYCLES-1. Required response: done=1, hang=0, timeout=0.
- Reset and restart:
  - rst pulse mid-RUN: required response is all outputs at their reset values next cycle, state IDLE.
  - start from DONE: required response is flags cleared, counters zeroed and a fresh RST_HOLD.
  - start during RUN: required response is none (ignored).
- Trace (RUNMON_TRACE_EN): 12 commits at PCs 1..12. Required response: trc_idx 0 gives 12, trc_idx 7 gives 5 (wrap-around verified).

Source files
------------

// File: rtl/runmon_pkg.sv
// Shared types for proc_run_monitor: run-state encoding, terminal status codes,
// and the saturating counter increment used by the cycle/instruction counters.
package runmon_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_RUN      = 3'd2,
    S_DONE     = 3'd3,
    S_TIMEOUT  = 3'd4,
    S_HANG     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'd0,
    STAT_DONE    = 2'd1,
    STAT_TIMEOUT = 2'd2,
    STAT_HANG    = 2'd3
  } status_e;

  typedef struct packed {
    logic hang;
    logic timeout;
    logic done;
  } flags_t;

  function automatic flags_t status_flags(input status_e s);
    flags_t f;
    f = '0;
    case (s)
      STAT_DONE:    f.done    = 1'b1;
      STAT_TIMEOUT: f.timeout = 1'b1;
      STAT_HANG:    f.hang    = 1'b1;
      default:      f         = '0;
    endcase
    return f;
  endfunction

  // Works on a 64-bit carrier; w selects the real counter width so the value sticks at all-ones.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v == top) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/runmon_trace_buf.sv
// Circular buffer of the most recently committed PCs; read index 0 is the newest entry.
module runmon_trace_buf
  import runmon_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr,
  input  logic [ADDR_W-1:0]          wr_pc,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [ADDR_W-1:0]          rd_pc
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wptr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wptr] <= wr_pc;
      wptr      <= wptr + IDX_W'(1);
    end
  end

  // DEPTH is a power of two, so the pointer arithmetic wraps for free.
  assign rd_pc = mem[wptr - IDX_W'(1) - rd_idx];

endmodule

// File: rtl/proc_run_monitor.sv
// Run controller/monitor for a multicycle core: reset sequencing, enable gating, counters,
// halt/hang/timeout detection. Define RUNMON_TRACE_EN to add the committed-PC trace buffer.
module proc_run_monitor
  import runmon_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 4,
  parameter int MAX_CYCLES  = 200,
  parameter int HANG_LIMIT  = 3,
  parameter int TRACE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_i,
  input  logic              commit_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              core_rst,
  output logic              core_en,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic              hang,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
`ifdef RUNMON_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trc_idx,
  output logic [ADDR_W-1:0]              trc_pc
`endif
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int HANG_W = $clog2(HANG_LIMIT + 1);

  state_e            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HANG_W-1:0] hang_cnt;
  logic [HANG_W-1:0] hang_next;
  logic [ADDR_W-1:0] last_pc;
  logic              hang_hit;
  logic              budget_end;

  // A cleared tracker (count 0) yields 1 on the first commit whether or not the PC matches.
  always_comb begin
    hang_next = hang_cnt;
    if (commit_i)
      hang_next = (pc_i == last_pc) ? hang_cnt + HANG_W'(1) : HANG_W'(1);
    hang_hit   = commit_i && (hang_next == HANG_W'(HANG_LIMIT));
    budget_end = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      core_rst  <= 1'b1;
      core_en   <= 1'b0;
      running   <= 1'b0;
      {hang, timeout, done} <= status_flags(STAT_NONE);
      cycle_cnt <= '0;
      instr_cnt <= '0;
      hold_cnt  <= '0;
      hang_cnt  <= '0;
      last_pc   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT, S_HANG: begin
          if (start) begin
            state     <= S_RST_HOLD;
            core_rst  <= 1'b1;
            core_en   <= 1'b0;
            running   <= 1'b0;
            {hang, timeout, done} <= status_flags(STAT_NONE);
            cycle_cnt <= '0;
            instr_cnt <= '0;
            hold_cnt  <= '0;
            hang_cnt  <= '0;
            last_pc   <= '0;
          end
        end
        S_RST_HOLD: begin
          if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
            state    <= S_RUN;
            core_rst <= 1'b0;
            core_en  <= 1'b1;
            running  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          cycle_cnt <= CNT_W'(sat_inc(64'(cycle_cnt), CNT_W));
          hang_cnt  <= hang_next;
          if (commit_i) begin
            instr_cnt <= CNT_W'(sat_inc(64'(instr_cnt), CNT_W));
            last_pc   <= pc_i;
          end
          // Exit priority: halt, then hang, then the cycle budget.
          if (halt_i || hang_hit || budget_end) begin
            core_en <= 1'b0;
            running <= 1'b0;
            if (halt_i) begin
              state <= S_DONE;
              {hang, timeout, done} <= status_flags(STAT_DONE);
            end else if (hang_hit) begin
              state <= S_HANG;
              {hang, timeout, done} <= status_flags(STAT_HANG);
            end else begin
              state <= S_TIMEOUT;
              {hang, timeout, done} <= status_flags(STAT_TIMEOUT);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RUNMON_TRACE_EN
  runmon_trace_buf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == S_RST_HOLD),
    .wr     ((state == S_RUN) && commit_i),
    .wr_pc  (pc_i),
    .rd_idx (trc_idx),
    .rd_pc  (trc_pc)
  );
`endif

endmodule

// File: tb/tb_proc_run_monitor.sv
// Self-checking bench for proc_run_monitor: directed scenarios plus randomized runs scored
// against an outcome model computed from the committed-PC history.
module tb_proc_run_monitor;

  localparam int MAXC = 200;
  localparam int RSTC = 4;
  localparam int HL   = 3;
  localparam int OUT_DONE = 1, OUT_TIMEOUT = 2, OUT_HANG = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_i = 1'b0;
  logic        commit_i = 1'b0;
  logic [15:0] pc_i = '0;
  logic        core_rst, core_en, running, done, timeout, hang;
  logic [31:0] cycle_cnt, instr_cnt;
`ifdef RUNMON_TRACE_EN
  logic [2:0]  trc_idx = '0;
  logic [15:0] trc_pc;
`endif

  int tests = 0;
  int fails = 0;

  bit          halt_a   [MAXC];
  bit          commit_a [MAXC];
  logic [15:0] pc_a     [MAXC];

  proc_run_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt_i    (halt_i),
    .commit_i  (commit_i),
    .pc_i      (pc_i),
    .core_rst  (core_rst),
    .core_en   (core_en),
    .running   (running),
    .done      (done),
    .timeout   (timeout),
    .hang      (hang),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`ifdef RUNMON_TRACE_EN
    ,
    .trc_idx   (trc_idx),
    .trc_pc    (trc_pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":core_rst"}, 64'(core_rst), 64'd1);
    chk({tag, ":core_en"}, 64'(core_en), 64'd0);
    chk({tag, ":running"}, 64'(running), 64'd0);
    chk({tag, ":flags"}, 64'({done, timeout, hang}), 64'd0);
    chk({tag, ":cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    chk({tag, ":instr_cnt"}, 64'(instr_cnt), 64'd0);
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      halt_a[k] = 1'b0;
      commit_a[k] = 1'b0;
      pc_a[k] = '0;
    end
  endtask

  // Outcome model: scan the RUN cycles in order; a hang is HL consecutive committed PCs
  // that are all equal; at a given cycle halt beats hang beats the last budgeted cycle.
  task automatic model(output int end_k, output int outcome, output int n_commit);
    logic [15:0] q[$];
    bit hung;
    end_k = MAXC - 1;
    outcome = OUT_TIMEOUT;
    n_commit = 0;
    for (int k = 0; k < MAXC; k++) begin
      hung = 1'b0;
      if (commit_a[k]) begin
        q.push_back(pc_a[k]);
        if (q.size() >= HL) begin
          hung = 1'b1;
          for (int j = 1; j < HL; j++)
            if (q[q.size() - 1 - j] != q[q.size() - 1]) hung = 1'b0;
        end
      end
      if (halt_a[k] || hung || k == MAXC - 1) begin
        end_k = k;
        n_commit = q.size();
        outcome = halt_a[k] ? OUT_DONE : (hung ? OUT_HANG : OUT_TIMEOUT);
        return;
      end
    end
  endtask

  task automatic run_check(input string tag, output int end_k_o);
    int end_k, outcome, n, seen;
    model(end_k, outcome, n);
    end_k_o = end_k;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_reset_vals({tag, ":hold_entry"});
    for (int i = 1; i < RSTC; i++) begin
      tick();
      chk({tag, ":hold_rst"}, 64'(core_rst), 64'd1);
      chk({tag, ":hold_en"}, 64'(core_en), 64'd0);
    end
    tick();
    chk({tag, ":run_entry"}, 64'({core_rst, core_en, running}), 64'b011);
    chk({tag, ":run_cnt0"}, 64'(cycle_cnt), 64'd0);
    seen = 0;
    for (int k = 0; k <= end_k; k++) begin
      halt_i = halt_a[k];
      commit_i = commit_a[k];
      pc_i = pc_a[k];
      start = (k < end_k) && ($urandom_range(0, 15) == 0);
      tick();
      seen += int'(commit_a[k]);
      if (k < end_k) begin
        chk({tag, ":running"}, 64'(running), 64'd1);
        chk({tag, ":cycle_cnt"}, 64'(cycle_cnt), 64'(k + 1));
        chk({tag, ":instr_cnt"}, 64'(instr_cnt), 64'(seen));
      end
    end
    halt_i = 1'b0;
    commit_i = 1'b0;
    start = 1'b0;
    chk({tag, ":done"}, 64'(done), 64'(outcome == OUT_DONE));
    chk({tag, ":timeout"}, 64'(timeout), 64'(outcome == OUT_TIMEOUT));
    chk({tag, ":hang"}, 64'(hang), 64'(outcome == OUT_HANG));
    chk({tag, ":end_ctl"}, 64'({core_rst, core_en, running}), 64'b000);
    chk({tag, ":end_cycles"}, 64'(cycle_cnt), 64'(end_k + 1));
    chk({tag, ":end_instr"}, 64'(instr_cnt), 64'(n));
    for (int i = 0; i < 3; i++) begin
      halt_i = 1'($urandom_range(0, 1));
      commit_i = 1'($urandom_range(0, 1));
      pc_i = 16'($urandom);
      tick();
      chk({tag, ":frozen_cycles"}, 64'(cycle_cnt), 64'(end_k + 1));
      chk({tag, ":frozen_instr"}, 64'(instr_cnt), 64'(n));
      chk({tag, ":frozen_en"}, 64'(core_en), 64'd0);
    end
    halt_i = 1'b0;
    commit_i = 1'b0;
  endtask

  task automatic gen_random();
    int mode, halt_at;
    clear_stim();
    mode = $urandom_range(0, 2);
    halt_at = (mode == 0) ? $urandom_range(0, MAXC - 1) :
              (mode == 1) ? $urandom_range(0, 3 * MAXC) : -1;
    for (int k = 0; k < MAXC; k++) begin
      commit_a[k] = ($urandom_range(0, 2) == 0);
      pc_a[k] = (mode == 1) ? 16'($urandom_range(0, 3) * 4) : 16'(k * 4 + 256);
      halt_a[k] = (k == halt_at);
    end
  endtask

  initial begin
    int ek;
    rst = 1'b1;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();
    chk_reset_vals("idle");

    // Normal halt: ten commits at distinct PCs, halt on RUN cycle 50.
    clear_stim();
    for (int i = 0; i < 10; i++) begin
      commit_a[2 * i + 2] = 1'b1;
      pc_a[2 * i + 2] = 16'(16'h0100 + 4 * i);
    end
    halt_a[50] = 1'b1;
    run_check("halt", ek);
    chk("halt:plan", 64'({done, core_en}), 64'b10);
    chk("halt:plan_cycles", 64'(cycle_cnt), 64'd51);
    chk("halt:plan_instr", 64'(instr_cnt), 64'd10);

    // Timeout with distinct PCs, restarted from DONE.
    clear_stim();
    for (int k = 0; k < MAXC; k += 3) begin
      commit_a[k] = 1'b1;
      pc_a[k] = 16'(16'h0200 + k);
    end
    run_check("timeout", ek);
    chk("timeout:plan", 64'({timeout, done}), 64'b10);
    chk("timeout:plan_cycles", 64'(cycle_cnt), 64'd200);

    // Hang: 0x10, 0x14, 0x14, 0x14.
    clear_stim();
    commit_a[1] = 1'b1; pc_a[1] = 16'h0010;
    commit_a[3] = 1'b1; pc_a[3] = 16'h0014;
    commit_a[5] = 1'b1; pc_a[5] = 16'h0014;
    commit_a[7] = 1'b1; pc_a[7] = 16'h0014;
    run_check("hang", ek);
    chk("hang:plan_end", 64'(ek), 64'd7);
    chk("hang:plan", 64'(hang), 64'd1);
    chk("hang:plan_instr", 64'(instr_cnt), 64'd4);

    // Halt, third repeated PC and last budgeted cycle all together.
    clear_stim();
    for (int k = MAXC - 3; k < MAXC; k++) begin
      commit_a[k] = 1'b1;
      pc_a[k] = 16'h0020;
    end
    halt_a[MAXC - 1] = 1'b1;
    run_check("simul", ek);
    chk("simul:plan", 64'({done, hang, timeout}), 64'b100);

    for (int r = 0; r < 8; r++) begin
      gen_random();
      run_check($sformatf("rand%0d", r), ek);
    end

    // Reset in the middle of a run.
    clear_stim();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < RSTC + 10; i++) begin
      commit_i = 1'($urandom_range(0, 1));
      pc_i = 16'(i);
      tick();
    end
    chk("midrun:pre", 64'(running), 64'd1);
    commit_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("midrun_rst");
    tick();
    chk_reset_vals("midrun_idle");

`ifdef RUNMON_TRACE_EN
    clear_stim();
    for (int k = 0; k < 12; k++) begin
      commit_a[k] = 1'b1;
      pc_a[k] = 16'(k + 1);
    end
    halt_a[12] = 1'b1;
    run_check("trace", ek);
    trc_idx = 3'd0;
    #1;
    chk("trace:idx0", 64'(trc_pc), 64'd12);
    trc_idx = 3'd7;
    #1;
    chk("trace:idx7", 64'(trc_pc), 64'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
